// File: rtl/alu_control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------------------------
// alu_control_pipe - registered ALU control decoder, valid/ready, 2-entry skid, error counter
// Optional feature macro: ALU_CTRL_SHIFT_EN (sll/srl decode).            Rev 1.0
// ------------------------------------------------------------------------------------------
module alu_control_pipe #(
  parameter int CTRL_W    = 4,
  parameter int FUNCT_W   = 6,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    alu_ctrl,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] main_ctrl;
  logic       main_ill;
  logic [3:0] skid_ctrl;
  logic       skid_ill;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       funct_hi;
  logic       acc;
  logic       drn;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  // Any set funct bit above the architectural 6 makes an R-type op undecodable.
  generate
    if (FUNCT_W > 6) begin : g_funct_hi
      assign funct_hi = |funct[FUNCT_W-1:6];
    end else begin : g_funct_nohi
      assign funct_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    {dec_ill, dec_ctrl} = 5'b1_1111;
    case (alu_op)
      3'b000: {dec_ill, dec_ctrl} = 5'b0_0010;
      3'b001: {dec_ill, dec_ctrl} = 5'b0_0110;
      3'b011: {dec_ill, dec_ctrl} = 5'b0_0000;
      3'b100: {dec_ill, dec_ctrl} = 5'b0_0001;
      3'b101: {dec_ill, dec_ctrl} = 5'b0_0111;
      3'b010: begin
        if (!funct_hi) begin
          case (funct[5:0])
            6'b100000: {dec_ill, dec_ctrl} = 5'b0_0010;
            6'b100010: {dec_ill, dec_ctrl} = 5'b0_0110;
            6'b100100: {dec_ill, dec_ctrl} = 5'b0_0000;
            6'b100101: {dec_ill, dec_ctrl} = 5'b0_0001;
            6'b101010: {dec_ill, dec_ctrl} = 5'b0_0111;
            6'b100110: {dec_ill, dec_ctrl} = 5'b0_0011;
            6'b100111: {dec_ill, dec_ctrl} = 5'b0_1100;
`ifdef ALU_CTRL_SHIFT_EN
            6'b000000: {dec_ill, dec_ctrl} = 5'b0_1000;
            6'b000010: {dec_ill, dec_ctrl} = 5'b0_1001;
`endif
            default:   {dec_ill, dec_ctrl} = 5'b1_1111;
          endcase
        end
      end
      default: {dec_ill, dec_ctrl} = 5'b1_1111;
    endcase
  end

  // out_valid and in_ready are registered alongside the state so neither depends
  // combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_ctrl <= 4'b0000;
      main_ill  <= 1'b0;
      skid_ctrl <= 4'b0000;
      skid_ill  <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state     <= ONE;
            main_ctrl <= dec_ctrl;
            main_ill  <= dec_ill;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (acc && !drn) begin
            state     <= TWO;
            skid_ctrl <= dec_ctrl;
            skid_ill  <= dec_ill;
            in_ready  <= 1'b0;
          end else if (!acc && drn) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (acc && drn) begin
            main_ctrl <= dec_ctrl;
            main_ill  <= dec_ill;
          end
        end
        TWO: begin
          if (drn) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_ill  <= skid_ill;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
      if (acc && dec_ill && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign alu_ctrl = CTRL_W'(main_ctrl);
  assign illegal  = main_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------------------------
// tb_alu_control_pipe - scoreboard bench for alu_control_pipe (honours ALU_CTRL_SHIFT_EN)
// Rev 1.0
// ------------------------------------------------------------------------------------------
module tb_alu_control_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [3:0] alu_ctrl,  alu_ctrl2;
  logic       illegal,   illegal2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  logic [4:0] sb[$];

  alu_control_pipe #(.CTRL_W(4), .FUNCT_W(6), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .illegal(illegal), .err_count(err_count)
  );

  alu_control_pipe #(.CTRL_W(4), .FUNCT_W(6), .ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .alu_op(alu_op), .funct(funct), .out_valid(out_valid2), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl2), .illegal(illegal2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] decode(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'b000: return 5'h02;
      3'b001: return 5'h06;
      3'b011: return 5'h00;
      3'b100: return 5'h01;
      3'b101: return 5'h07;
      3'b010: begin
        case (f)
          6'h20: return 5'h02;
          6'h22: return 5'h06;
          6'h24: return 5'h00;
          6'h25: return 5'h01;
          6'h2a: return 5'h07;
          6'h26: return 5'h03;
          6'h27: return 5'h0c;
`ifdef ALU_CTRL_SHIFT_EN
          6'h00: return 5'h08;
          6'h02: return 5'h09;
`endif
          default: return 5'h1f;
        endcase
      end
      default: return 5'h1f;
    endcase
  endfunction

  // Inputs change 1ns after posedge, so everything seen here is what the next edge will use.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, sb.size() < 2);
      check("out_valid_w2", out_valid2, sb.size() != 0);
      check("err_count", err_count, err_exp);
      check("err_count_w2", err_count2, (err_exp > 3) ? 3 : err_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("alu_ctrl", alu_ctrl, e[3:0]);
          check("illegal", illegal, e[4]);
          check("alu_ctrl_w2", alu_ctrl2, e[3:0]);
        end
      end
      if (in_valid && in_ready) begin
        e = decode(alu_op, funct);
        sb.push_back(e);
        if (e[4]) err_exp++;
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f, input logic ordy);
    in_valid  = v;
    alu_op    = op;
    funct     = f;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [2:0] op, input logic [5:0] f, input logic ordy);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      in_valid  = 1'b1;
      alu_op    = op;
      funct     = f;
      out_ready = ordy;
      got       = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", got, 1);
  endtask

  logic [2:0] ops1[5]  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
  logic [5:0] fns[7]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h26, 6'h27};

  initial begin
    logic [5:0] rf;
    rst = 1'b0; in_valid = 1'b0; alu_op = 3'b000; funct = 6'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_illegal", illegal, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b1;

    // Non-R-type classes back-to-back, then every R-type funct.
    foreach (ops1[i]) drive(1'b1, ops1[i], 6'h00, 1'b1);
    foreach (fns[i]) drive(1'b1, 3'b010, fns[i], 1'b1);
    repeat (2) drive(1'b0, 3'b000, 6'h00, 1'b1);

    // Back-pressure: fill both entries, stall a third, then drain.
    drive(1'b1, 3'b000, 6'h00, 1'b0);
    drive(1'b1, 3'b001, 6'h00, 1'b0);
    check("full_in_ready", in_ready, 0);
    drive(1'b1, 3'b011, 6'h00, 1'b0);
    push_hold(3'b011, 6'h00, 1'b1);
    repeat (3) drive(1'b0, 3'b000, 6'h00, 1'b1);

    // Illegal ops and counter saturation in the narrow instance.
    drive(1'b1, 3'b110, 6'h00, 1'b1);
    drive(1'b1, 3'b010, 6'h3f, 1'b1);
    drive(1'b0, 3'b000, 6'h00, 1'b1);
    check("err_two", err_count, 2);
    drive(1'b1, 3'b111, 6'h00, 1'b1);
    drive(1'b1, 3'b010, 6'h01, 1'b1);
    drive(1'b1, 3'b010, 6'h2b, 1'b1);
    drive(1'b0, 3'b000, 6'h00, 1'b1);
    check("err_five", err_count, 5);
    check("err_sat_w2", err_count2, 3);

    // Shift functs: legal only with the feature macro.
    drive(1'b1, 3'b010, 6'h00, 1'b1);
    drive(1'b1, 3'b010, 6'h02, 1'b1);
    drive(1'b0, 3'b000, 6'h00, 1'b1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 60; i++) begin
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      drive(1'($urandom), 3'($urandom), rf, 1'($urandom_range(0, 2) != 0));
    end
    repeat (3) drive(1'b0, 3'b000, 6'h00, 1'b1);

    // Asynchronous reset while both entries are full.
    drive(1'b1, 3'b000, 6'h00, 1'b0);
    drive(1'b1, 3'b110, 6'h00, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_err_count", err_count, 0);
    check("arst_err_count_w2", err_count2, 0);
    sb.delete();
    err_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 3'b100, 6'h00, 1'b1);
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_alu_ctrl", alu_ctrl, 4'b0001);
    repeat (3) drive(1'b0, 3'b000, 6'h00, 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
